// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/busy/done handshake and result bus for bin2bcd_seq
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic                  sign;

  modport master (output start, bin, input busy, done, bcd, overflow, sign);
  modport slave  (input start, bin, output busy, done, bcd, overflow, sign);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - one-bit-per-clock double-dabble binary to BCD converter
// Optional two's-complement input enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bin2bcd_seq_if.slave     bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;

  if (BIN_W < 2) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be >= 2");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digs_q, digs_d;
  logic [BIN_W-1:0]   opnd_q, opnd_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               sign_q, sign_d;
  logic               sign_w_q, sign_w_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   digs_sh;
  logic [BIN_W-1:0]   opnd_sh;
  logic               shift_out;
  logic [BIN_W-1:0]   mag;
  logic               bin_neg;
  logic               accept;

  always_comb begin
    adj = digs_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digs_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = digs_q[4*i +: 4] + 4'd3;
    end
    // A carry out of the top digit means the operand needs more digits than we have.
    shift_out = adj[BCD_W-1];
    digs_sh   = {adj[BCD_W-2:0], opnd_q[BIN_W-1]};
    opnd_sh   = {opnd_q[BIN_W-2:0], 1'b0};
  end

`ifdef BIN2BCD_SIGNED_EN
  always_comb begin
    bin_neg = bus.bin[BIN_W-1];
    // Unsigned negate: the most negative value maps onto its own bit pattern, which is the right magnitude.
    mag     = bin_neg ? ((~bus.bin) + BIN_W'(1)) : bus.bin;
  end
`else
  always_comb begin
    bin_neg = 1'b0;
    mag     = bus.bin;
  end
`endif

  assign accept = bus.start && (state_q != S_SHIFT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digs_d    = digs_q;
    opnd_d    = opnd_q;
    acc_ovf_d = acc_ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    sign_d    = sign_q;
    sign_w_d  = sign_w_q;
    case (state_q)
      S_SHIFT: begin
        digs_d    = digs_sh;
        opnd_d    = opnd_sh;
        acc_ovf_d = acc_ovf_q | shift_out;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = digs_sh;
          ovf_d   = acc_ovf_q | shift_out;
          sign_d  = sign_w_q;
        end
      end
      default: begin
        if (accept) begin
          state_d   = S_SHIFT;
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(BIN_W - 1);
          digs_d    = '0;
          opnd_d    = mag;
          acc_ovf_d = 1'b0;
          sign_w_d  = bin_neg;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      digs_q    <= '0;
      opnd_q    <= '0;
      acc_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      sign_q    <= 1'b0;
      sign_w_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digs_q    <= digs_d;
      opnd_q    <= opnd_d;
      acc_ovf_q <= acc_ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      sign_q    <= sign_d;
      sign_w_q  <= sign_w_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.sign     = sign_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus ();

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one conversion, scramble bin while busy, and wait for done.
  task automatic run_conv(input string name, input logic [13:0] v, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input logic exp_sign,
                          input bit chk_hold, input logic [15:0] hold_val);
    int n;
    int busy_n;
    bus.bin   = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin   = ~v;
    n = 0;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && n < 40) begin
      if (chk_hold) begin
        checks++;
        if (bus.bcd !== hold_val) begin
          errors++;
          $display("FAIL %s_hold: bcd=%h required %h at cycle %0d", name, bus.bcd, hold_val, n);
        end
      end
      tick();
      n++;
      if (bus.busy) busy_n++;
    end
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL %s_latency: %0d cycles required 14", name, n);
    end
    checks++;
    if (busy_n !== 14) begin
      errors++;
      $display("FAIL %s_busy_cycles: %0d required 14", name, busy_n);
    end
    checks++;
    if (bus.bcd !== exp_bcd) begin
      errors++;
      $display("FAIL %s_bcd: %h required %h", name, bus.bcd, exp_bcd);
    end
    checks++;
    if (bus.overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s_ovf: %b required %b", name, bus.overflow, exp_ovf);
    end
    checks++;
    if (bus.sign !== exp_sign) begin
      errors++;
      $display("FAIL %s_sign: %b required %b", name, bus.sign, exp_sign);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b required 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin = '0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.bcd, bus.overflow, bus.sign} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h ovf=%b sign=%b required all 0",
               bus.busy, bus.done, bus.bcd, bus.overflow, bus.sign);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_conv("b9999", 14'd9999, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0);
    run_conv("b0", 14'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
    run_conv("b1234", 14'd1234, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_overflow();
    run_conv("b16383", 14'd16383, 16'h6383, 1'b1, 1'b0, 1'b0, 16'h0);
    run_conv("b42", 14'd42, 16'h0042, 1'b0, 1'b0, 1'b1, 16'h6383);
  endtask

  task automatic test_back_to_back();
    int n;
    bus.bin   = 14'd7;
    bus.start = 1'b1;
    tick();
    bus.bin = 14'd8000;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 14 || bus.bcd !== 16'h0007) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d bcd=%h required 14 0007", n, bus.bcd);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reaccept: done=%b busy=%b required 0 1", bus.done, bus.busy);
    end
    bus.bin = 14'd1111;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 14 || bus.bcd !== 16'h8000) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d bcd=%h required 14 8000", n, bus.bcd);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mid_start_ignored();
    int n;
    bus.bin   = 14'd250;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.bin   = 14'd9876;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 5;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 14 || bus.bcd !== 16'h0250) begin
      errors++;
      $display("FAIL mid_start: cycles=%0d bcd=%h required 14 0250", n, bus.bcd);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_start_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    bus.bin   = 14'd1234;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 16'h0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b bcd=%h ovf=%b required 0 0 0000 0",
               bus.busy, bus.done, bus.bcd, bus.overflow);
    end
    dones = 0;
    repeat (20) begin
      tick();
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d done pulses required 0", dones);
    end
    run_conv("post_abort", 14'd4321, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_sign();
`ifdef BIN2BCD_SIGNED_EN
    run_conv("neg1234", 14'd15150, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0);
    run_conv("neg8192", 14'd8192, 16'h8192, 1'b0, 1'b1, 1'b0, 16'h0);
    run_conv("zero_sign", 14'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
`else
    run_conv("unsigned_3fff", 14'h3FFF, 16'h6383, 1'b1, 1'b0, 1'b0, 16'h0);
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_mid_start_ignored();
    test_reset_abort();
    test_sign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
